// File: rtl/fetch_unit_pkg.sv
// Shared widths, constants and FSM encoding for the instruction-fetch stage.
package fetch_unit_pkg;

    localparam int InstAddrBus = 16;
    localparam int InstBus     = 16;

    localparam logic RstEnable  = 1'b1;
    localparam logic RstDisable = 1'b0;

    localparam logic [InstBus-1:0]     NopInst  = 16'h0800;
    localparam logic [InstAddrBus-1:0] ZeroWord = '0;

    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_HOLD = 1'b1
    } fetch_state_e;

    // Fetch address chosen when the current word is accepted: a live branch wins,
    // then a redirect deferred from an earlier unacked cycle, else sequential.
    function automatic logic [InstAddrBus-1:0] next_fetch_addr(
        input logic                   take_br,
        input logic [InstAddrBus-1:0] br_addr,
        input logic                   pend,
        input logic [InstAddrBus-1:0] pend_tgt,
        input logic [InstAddrBus-1:0] fa
    );
        logic [InstAddrBus-1:0] nxt;
        if (take_br) begin
            nxt = br_addr;
        end else if (pend) begin
            nxt = pend_tgt;
        end else begin
            nxt = fa + 16'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fetch_unit_if_id.sv
// IF/ID pipeline latch: load a fetched word, insert a bubble, or hold while stalled.
module fetch_unit_if_id
    import fetch_unit_pkg::*;
#(
    parameter logic [InstBus-1:0] NOP_INST = NopInst
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic                   bubble_i,
    input  logic [InstAddrBus-1:0] pc_i,
    input  logic [InstBus-1:0]     inst_i,
    output logic [InstAddrBus-1:0] pc_o,
    output logic [InstBus-1:0]     inst_o,
    output logic                   valid_o
);

    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic [InstBus-1:0]     inst_q, inst_d;
    logic                   valid_q, valid_d;

    // A bubble keeps the old PC so id still sees a meaningful pc_i.
    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (load_i) begin
            pc_d    = pc_i;
            inst_d  = inst_i;
            valid_d = 1'b1;
        end else if (bubble_i) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pc_q    <= ZeroWord;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues fetches, handles stall, delayed branch
// redirect and memory-busy bubbles, and drives the IF/ID latch.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = 16'h0000,
    parameter logic [InstBus-1:0]     NOP_INST = NopInst
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   branch_flag_i,
    input  logic [InstAddrBus-1:0] branch_addr_i,
    output logic                   imem_req_o,
    output logic [InstAddrBus-1:0] imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [InstBus-1:0]     imem_data_i,
    output logic [InstAddrBus-1:0] pc_o,
    output logic [InstBus-1:0]     inst_o,
    output logic                   inst_valid_o,
    output logic                   fetch_busy_o
);

    fetch_state_e state_q, state_d;

    logic [InstAddrBus-1:0] fa_q, fa_d;
    logic                   pend_q, pend_d;
    logic [InstAddrBus-1:0] pend_tgt_q, pend_tgt_d;
    logic [InstAddrBus-1:0] buf_pc_q, buf_pc_d;
    logic [InstBus-1:0]     buf_inst_q, buf_inst_d;

    logic                   take_br;
    logic                   latch_load;
    logic                   latch_bubble;
    logic [InstAddrBus-1:0] latch_pc;
    logic [InstBus-1:0]     latch_inst;

    assign take_br = branch_flag_i && !stall_i;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= ST_REQ;
            fa_q    <= RESET_PC;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fa_q    <= fa_d;
            pend_q  <= pend_d;
        end
    end

    // Buffer and redirect target are only meaningful under state/pend, so no reset.
    always_ff @(posedge clk) begin
        pend_tgt_q <= pend_tgt_d;
        buf_pc_q   <= buf_pc_d;
        buf_inst_q <= buf_inst_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_REQ:  if (imem_ack_i && stall_i) state_d = ST_HOLD;
            ST_HOLD: if (!stall_i) state_d = ST_REQ;
            default: state_d = ST_REQ;
        endcase
    end

    always_comb begin
        fa_d       = fa_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        unique case (state_q)
            ST_REQ: begin
                if (imem_ack_i) begin
                    fa_d   = next_fetch_addr(take_br, branch_addr_i, pend_q, pend_tgt_q, fa_q);
                    pend_d = 1'b0;
                    if (stall_i) begin
                        buf_pc_d   = fa_q;
                        buf_inst_d = imem_data_i;
                    end
                end else if (take_br) begin
                    // The word still in flight is the delay slot; redirect once it lands.
                    pend_d     = 1'b1;
                    pend_tgt_d = branch_addr_i;
                end
            end
            ST_HOLD: begin
                if (take_br) fa_d = branch_addr_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        imem_req_o   = (state_q == ST_REQ) && (rst == RstDisable);
        imem_addr_o  = fa_q;
        fetch_busy_o = (state_q == ST_REQ) && !imem_ack_i;
        latch_load   = 1'b0;
        latch_bubble = 1'b0;
        latch_pc     = fa_q;
        latch_inst   = imem_data_i;
        if (!stall_i) begin
            if (state_q == ST_HOLD) begin
                latch_load = 1'b1;
                latch_pc   = buf_pc_q;
                latch_inst = buf_inst_q;
            end else if (imem_ack_i) begin
                latch_load = 1'b1;
            end else begin
                latch_bubble = 1'b1;
            end
        end
    end

    fetch_unit_if_id #(
        .NOP_INST(NOP_INST)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load_i   (latch_load),
        .bubble_i (latch_bubble),
        .pc_i     (latch_pc),
        .inst_i   (latch_inst),
        .pc_o     (pc_o),
        .inst_o   (inst_o),
        .valid_o  (inst_valid_o)
    );

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 16-bit pipelined CPU, directly upstream of `id`. Owns the program counter, issues word fetches to the shared instruction/data memory port, and drives the IF/ID pipeline latch (`pc_o`/`inst_o` feed `id` inputs `pc_i`/`inst_i`). Honours pipeline stall from `ctrl`, applies branch redirects from `id` with one architectural delay slot, and inserts NOP bubbles while memory is busy.

## Interface
- `RESET_PC`, 16'h0000: PC after reset.
- `NOP_INST`, 16'h0800: bubble instruction placed in the latch.
- `clk  in  1`: single clock; all state updates on rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `stall_i  in  1`: `ctrl` stall of IF/ID; high means `id` does not consume the latch this cycle.
- `branch_flag_i  in  1`: from `id` `branch_flag_o`; taken branch/jump.
- `branch_addr_i  in  16`: from `id` `branch_addr_o`; target.
- `imem_req_o  out  1`: fetch request.
- `imem_addr_o  out  16`: fetch word address (= `fa`).
- `imem_ack_i  in  1`: data valid this cycle; may be same cycle as request; low while MEM stage owns the port.
- `imem_data_i  in  16`: fetched instruction.
- `pc_o  out  16`: IF/ID PC of `inst_o`.
- `inst_o  out  16`: IF/ID instruction.
- `inst_valid_o  out  1`: latch holds a real instruction (0 = bubble).
- `fetch_busy_o  out  1`: `state==REQ && !imem_ack_i`.

## Operation
- State: `fa` (next fetch address), FSM {REQ, HOLD}, 1-entry buffer `buf_inst/buf_pc`, `pend` + `pend_tgt` (deferred redirect).
- Reset: `fa=RESET_PC`, state REQ, `pend=0`, `pc_o=0`, `inst_o=NOP_INST`, `inst_valid_o=0`, `imem_req_o` low during reset cycle.
- REQ: `imem_req_o=1`, `imem_addr_o=fa`. On `imem_ack_i`:
  - `stall_i=0`: latch <= {`fa`, `imem_data_i`, valid=1}; stay REQ.
  - `stall_i=1`: buffer <= {`fa`, data}; go HOLD (req low).
  - Either way `fa` <= next address (below).
- REQ without ack and `stall_i=0`: latch <= bubble (`inst_o=NOP_INST`, valid 0, `pc_o` held). `stall_i=1`: latch held.
- HOLD: req low. When `stall_i=0`: latch <= buffer, valid=1, go REQ.
- Next address at ack: `branch_flag_i && !stall_i` same cycle -> `branch_addr_i`; else `pend` -> `pend_tgt`, clear `pend`; else `fa+1` (16-bit wrap, 16'hFFFF -> 0).
- Branch (`branch_flag_i && !stall_i`): REQ without ack -> `pend<=1`, `pend_tgt<=branch_addr_i` (in-flight fetch is the delay slot, completes normally). HOLD -> buffered word is the delay slot; `fa<=branch_addr_i` directly. `branch_flag_i` ignored while `stall_i=1`.
- Delay slot never squashed; no fetch from an address other than `fa`.

## Timing
- Ack with `imem_req_o` in cycle t -> `inst_o` valid from t+1; back-to-back 1 word/cycle with constant ack.
- Taken branch in id at cycle t with delay slot acked at t -> target fetched at t+1, visible t+2.
- `stall_i` freezes latch exactly; each fetched word reaches `id` once, in order.
- Reset mid-fetch: request dropped that cycle, pending redirect and buffer discarded, next request at `RESET_PC` the cycle after reset deasserts.

## Structure
- Shared defines: `RstEnable`/`RstDisable`, `NopInst` (16'h0800), `ZeroWord`, FSM state encodings, `InstAddrBus`/`InstBus` widths.
- One sub-module: `if_id` (IF/ID latch: load, hold, bubble, reset); FSM, `fa`, buffer, redirect logic in `fetch_unit`.

## Test plan
- Reset, ack tied 1, no stall -> addresses 0,1,2,3 on consecutive cycles; `inst_o` follows one cycle later, valid=1.
- Ack low cycles 2-3 -> `inst_o=16'h0800`, valid 0, `fa` held at 2, resumes with 2 when ack returns.
- `stall_i` high during ack of addr 5 -> HOLD, req low, latch held; stall drop -> addr 5 delivered, fetch 6 next.
- Branch to 16'h0040 with id at pc 10, addr 11 acked same cycle -> next request 16'h0040; 11 delivered before 0x40.
- Branch to 16'h0080 while addr 11 unacked 3 cycles -> 11 completes, then 16'h0080; also `fa=16'hFFFF` -> next 0.
- Assert `rst` with pending redirect and full buffer -> outputs reset values, next request address 0.
